// File: rtl/mem_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl_if
//   CPU-side request/response channels of the RAM bus controller.
//   Request channel  : req_valid/req_ready handshake carrying op, addr,
//                      wdata and fill length.
//   Response channel : rsp_valid/rsp_ready handshake carrying read data.
//   Modports         : master (CPU side), slave (controller side).
// ---------------------------------------------------------------------------
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
//   Single-port bus master for a 16-bit x 24-bit-address RAM. Accepts
//   read / write / fill requests, sequences the RAM we/oe/addr pins, owns the
//   shared tristate data bus and returns read data on a response channel.
// Ports
//   clk          system clock, all state on posedge
//   r            synchronous active-high reset
//   bus          request/response channels (slave modport)
//   o_busy       controller not idle
//   o_mem_we     RAM write enable (registered)
//   o_mem_oe     RAM output enable (registered)
//   o_mem_addr   RAM address (registered)
//   io_mem_data  RAM data bus, driven only while o_mem_we=1
// ---------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              r,
  mem_bus_ctrl_if.slave     bus,
  output logic              o_busy,
  output logic              o_mem_we,
  output logic              o_mem_oe,
  output logic [ADDR_W-1:0] o_mem_addr,
  inout  wire  [DATA_W-1:0] io_mem_data
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RESP, S_WR, S_FILL} state_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic              r_oe;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [LEN_W-1:0]  r_cnt;

  logic              w_we_nxt;
  logic              w_oe_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic              w_hs;

  assign bus.req_ready = (r_state == S_IDLE) && !r;
  assign w_hs          = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = r_rdata;
  assign o_busy        = (r_state != S_IDLE);
  assign o_mem_we      = r_we;
  assign o_mem_oe      = r_oe;
  assign o_mem_addr    = r_addr;
  assign io_mem_data   = r_we ? r_wdata : {DATA_W{1'bz}};

  // Next-state and next-pin decode. we/oe default low so every state that
  // does not explicitly request a bus cycle releases the RAM pins.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_oe_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          case (bus.req_op)
            OP_RD: begin
              w_state_nxt = S_RD;
              w_oe_nxt    = 1'b1;
              w_addr_nxt  = bus.req_addr;
            end
            OP_WR: begin
              w_state_nxt = S_WR;
              w_we_nxt    = 1'b1;
              w_addr_nxt  = bus.req_addr;
              w_wdata_nxt = bus.req_wdata;
            end
            OP_FILL: begin
              // Zero-length fill completes in IDLE without touching the bus.
              if (bus.req_len != '0) begin
                w_state_nxt = S_FILL;
                w_we_nxt    = 1'b1;
                w_addr_nxt  = bus.req_addr;
                w_wdata_nxt = bus.req_wdata;
                w_cnt_nxt   = bus.req_len;
              end
            end
            default: ;
          endcase
        end
      end
      S_RD: begin
        w_rdata_nxt = io_mem_data;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        // Holding here with oe low also gives the mandatory idle bus cycle
        // between a read and any following write.
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      S_WR: begin
        w_state_nxt = S_IDLE;
      end
      S_FILL: begin
        w_cnt_nxt = r_cnt - LEN_W'(1);
        if (r_cnt == LEN_W'(1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = r_addr + ADDR_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (r) r_state <= S_IDLE;
    else   r_state <= w_state_nxt;
  end

  // Registered RAM pins, fill counter and read data
  always_ff @(posedge clk) begin
    if (r) begin
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_we    <= w_we_nxt;
      r_oe    <= w_oe_nxt;
      r_addr  <= w_addr_nxt;
      r_rdata <= w_rdata_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Write data has no reset; it only reaches the bus while r_we is set.
  always_ff @(posedge clk) begin
    r_wdata <= w_wdata_nxt;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_ctrl
//   Bench for mem_bus_ctrl: behavioural RAM on the tristate bus, write and
//   read scoreboards, a request table, and hand sequences for reset, latency,
//   response back-pressure and fill abort.
// ---------------------------------------------------------------------------
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        r   = 1'b1;
  logic        clr = 1'b1;
  logic        busy, mem_we, mem_oe;
  logic [23:0] mem_addr;
  wire  [15:0] mem_data;
  logic [15:0] tb_bus;
  logic [15:0] ram [0:4095];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct packed {logic [23:0] a; logic [15:0] d;} wr_t;
  wr_t         wq[$];
  logic [15:0] rq[$];
  wr_t         w_e;

  typedef struct {
    logic [1:0]  op;
    logic [23:0] a;
    logic [15:0] d;
    logic [15:0] len;
    int          beats;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [20];

  mem_bus_ctrl_if u_if ();

  mem_bus_ctrl u_dut (
    .clk         (clk),
    .r           (r),
    .bus         (u_if),
    .o_busy      (busy),
    .o_mem_we    (mem_we),
    .o_mem_oe    (mem_oe),
    .o_mem_addr  (mem_addr),
    .io_mem_data (mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] idx(input logic [23:0] a);
    return {a[23], a[10:0]};
  endfunction

  // RAM model: drives read data under oe, otherwise a marker pattern, and
  // releases the bus whenever the controller asserts we.
  always_comb tb_bus = mem_oe ? ram[idx(mem_addr)] : 16'hA5C3;
  assign mem_data = mem_we ? 16'bz : tb_bus;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 16'h0000;
    end else if (mem_we) begin
      ram[idx(mem_addr)] <= mem_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", {8'h0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          w_e = wq.pop_front();
          chk("wr_addr", {8'h0, mem_addr}, {8'h0, w_e.a});
          chk("wr_data", {16'h0, mem_data}, {16'h0, w_e.d});
        end
      end
      if (u_if.rsp_valid && u_if.rsp_ready) begin
        if (rq.size() == 0) chk("unexpected_rsp", {16'h0, u_if.rsp_data}, 32'hFFFF_FFFF);
        else chk("rsp_data", {16'h0, u_if.rsp_data}, {16'h0, rq.pop_front()});
      end
      chk("we_oe_excl", {31'h0, mem_we & mem_oe}, 32'h0);
      if (!mem_we) chk("bus_release", {16'h0, mem_data}, {16'h0, tb_bus});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns in the cycle after the handshake edge.
  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [15:0] d,
                       input logic [15:0] len, input int beats, input logic [15:0] exp);
    int  k;
    wr_t w;
    k = 0;
    u_if.req_valid = 1'b1;
    u_if.req_op    = op;
    u_if.req_addr  = a;
    u_if.req_wdata = d;
    u_if.req_len   = len;
    while (!u_if.req_ready && k < 100) begin
      tick();
      k++;
    end
    if (!u_if.req_ready) begin
      chk("req_ready_timeout", 32'h0, 32'h1);
      u_if.req_valid = 1'b0;
    end else begin
      tick();
      u_if.req_valid = 1'b0;
      for (int i = 0; i < beats; i++) begin
        w.a = a + 24'(i);
        w.d = d;
        wq.push_back(w);
      end
      if (op == 2'b00) rq.push_back(exp);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy || wq.size() != 0 || rq.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    chk("drain_queues", wq.size() + rq.size(), 32'h0);
    chk("drain_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.req_valid = 1'b0;
    u_if.req_op    = 2'b00;
    u_if.req_addr  = '0;
    u_if.req_wdata = '0;
    u_if.req_len   = '0;
    u_if.rsp_ready = 1'b1;

    tbl[0]  = '{2'b01, 24'h001234, 16'hBEEF, 16'd0, 1, 16'h0000};
    tbl[1]  = '{2'b00, 24'h001234, 16'h0000, 16'd0, 0, 16'hBEEF};
    tbl[2]  = '{2'b01, 24'h000010, 16'h1111, 16'd0, 1, 16'h0000};
    tbl[3]  = '{2'b01, 24'h000011, 16'h2222, 16'd0, 1, 16'h0000};
    tbl[4]  = '{2'b00, 24'h000011, 16'h0000, 16'd0, 0, 16'h2222};
    tbl[5]  = '{2'b00, 24'h000010, 16'h0000, 16'd0, 0, 16'h1111};
    tbl[6]  = '{2'b10, 24'h000100, 16'h7777, 16'd3, 3, 16'h0000};
    tbl[7]  = '{2'b00, 24'h000102, 16'h0000, 16'd0, 0, 16'h7777};
    tbl[8]  = '{2'b00, 24'h000103, 16'h0000, 16'd0, 0, 16'h0000};
    tbl[9]  = '{2'b10, 24'hFFFFFE, 16'h5A5A, 16'd4, 4, 16'h0000};
    tbl[10] = '{2'b00, 24'hFFFFFE, 16'h0000, 16'd0, 0, 16'h5A5A};
    tbl[11] = '{2'b00, 24'hFFFFFF, 16'h0000, 16'd0, 0, 16'h5A5A};
    tbl[12] = '{2'b00, 24'h000000, 16'h0000, 16'd0, 0, 16'h5A5A};
    tbl[13] = '{2'b00, 24'h000001, 16'h0000, 16'd0, 0, 16'h5A5A};
    tbl[14] = '{2'b00, 24'h000002, 16'h0000, 16'd0, 0, 16'h0000};
    tbl[15] = '{2'b01, 24'h000010, 16'hFFFF, 16'd0, 1, 16'h0000};
    tbl[16] = '{2'b10, 24'h000010, 16'hDEAD, 16'd0, 0, 16'h0000};
    tbl[17] = '{2'b11, 24'h000010, 16'hDEAD, 16'd5, 0, 16'h0000};
    tbl[18] = '{2'b00, 24'h000010, 16'h0000, 16'd0, 0, 16'hFFFF};
    tbl[19] = '{2'b00, 24'h000011, 16'h0000, 16'd0, 0, 16'h2222};

    // Reset held for two cycles
    tick();
    clr = 1'b0;
    tick();
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_oe", {31'h0, mem_oe}, 32'h0);
    chk("rst_rsp_valid", {31'h0, u_if.rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, u_if.req_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_addr", {8'h0, mem_addr}, 32'h0);
    chk("rst_rsp_data", {16'h0, u_if.rsp_data}, 32'h0);
    r = 1'b0;
    tick();
    chk("post_rst_req_ready", {31'h0, u_if.req_ready}, 32'h1);

    // Request table
    for (int i = 0; i < 20; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].len, tbl[i].beats, tbl[i].exp);
    end
    drain();

    // Write then read latency
    issue(2'b01, 24'h001234, 16'hBEEF, 16'd0, 1, 16'h0000);
    chk("wr_t1_we", {31'h0, mem_we}, 32'h1);
    chk("wr_t1_ready", {31'h0, u_if.req_ready}, 32'h0);
    chk("wr_t1_addr", {8'h0, mem_addr}, 32'h001234);
    tick();
    chk("wr_t2_ready", {31'h0, u_if.req_ready}, 32'h1);
    chk("wr_t2_we", {31'h0, mem_we}, 32'h0);
    issue(2'b00, 24'h001234, 16'h0000, 16'd0, 0, 16'hBEEF);
    chk("rd_t1_oe", {31'h0, mem_oe}, 32'h1);
    chk("rd_t1_rsp_valid", {31'h0, u_if.rsp_valid}, 32'h0);
    tick();
    chk("rd_t2_rsp_valid", {31'h0, u_if.rsp_valid}, 32'h1);
    chk("rd_t2_data", {16'h0, u_if.rsp_data}, 32'hBEEF);
    chk("rd_t2_oe", {31'h0, mem_oe}, 32'h0);
    tick();
    chk("rd_t3_rsp_valid", {31'h0, u_if.rsp_valid}, 32'h0);
    chk("rd_t3_ready", {31'h0, u_if.req_ready}, 32'h1);

    // Response back-pressure for five cycles
    u_if.rsp_ready = 1'b0;
    issue(2'b00, 24'h000011, 16'h0000, 16'd0, 0, 16'h2222);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'h0, u_if.rsp_valid}, 32'h1);
      chk("bp_rsp_data", {16'h0, u_if.rsp_data}, 32'h2222);
      chk("bp_req_ready", {31'h0, u_if.req_ready}, 32'h0);
      chk("bp_oe", {31'h0, mem_oe}, 32'h0);
      tick();
    end
    u_if.rsp_ready = 1'b1;
    chk("bp_accept_valid", {31'h0, u_if.rsp_valid}, 32'h1);
    tick();
    chk("bp_idle_busy", {31'h0, busy}, 32'h0);
    chk("bp_idle_ready", {31'h0, u_if.req_ready}, 32'h1);

    // Fill of 8 aborted by reset during beat 3
    issue(2'b10, 24'h000200, 16'h3C3C, 16'd8, 3, 16'h0000);
    chk("ab_b1_we", {31'h0, mem_we}, 32'h1);
    chk("ab_b1_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("ab_b2_addr", {8'h0, mem_addr}, 32'h000201);
    tick();
    r = 1'b1;
    chk("ab_b3_we", {31'h0, mem_we}, 32'h1);
    chk("ab_b3_ready", {31'h0, u_if.req_ready}, 32'h0);
    tick();
    r = 1'b0;
    chk("ab_after_we", {31'h0, mem_we}, 32'h0);
    chk("ab_after_busy", {31'h0, busy}, 32'h0);
    chk("ab_after_pending", wq.size(), 32'h0);
    tick();
    chk("ab_after2_we", {31'h0, mem_we}, 32'h0);
    issue(2'b00, 24'h000202, 16'h0000, 16'd0, 0, 16'h3C3C);
    issue(2'b00, 24'h000203, 16'h0000, 16'd0, 0, 16'h0000);
    issue(2'b00, 24'h000207, 16'h0000, 16'd0, 0, 16'h0000);
    drain();

    // Zero-length fill and reserved op: no bus activity
    issue(2'b10, 24'h000300, 16'hDEAD, 16'd0, 0, 16'h0000);
    chk("len0_ready", {31'h0, u_if.req_ready}, 32'h1);
    chk("len0_we", {31'h0, mem_we}, 32'h0);
    chk("len0_oe", {31'h0, mem_oe}, 32'h0);
    chk("len0_busy", {31'h0, busy}, 32'h0);
    issue(2'b11, 24'h000300, 16'hDEAD, 16'd3, 0, 16'h0000);
    chk("op3_ready", {31'h0, u_if.req_ready}, 32'h1);
    chk("op3_we", {31'h0, mem_we}, 32'h0);
    chk("op3_oe", {31'h0, mem_oe}, 32'h0);
    tick();
    chk("op3_we_next", {31'h0, mem_we}, 32'h0);
    issue(2'b00, 24'h000300, 16'h0000, 16'd0, 0, 16'h0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
